// File: rtl/hdr_cmd_sequencer.sv
// rtl/hdr_cmd_sequencer.sv - HDR command chain sequencer between command queue and hdr_engine
module hdr_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int TID_W = 4,
    parameter int TO_W  = 10
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_cp,
    input  logic             i_cmd_toc,
    input  logic [2:0]       i_cmd_mode,
    input  logic [TID_W-1:0] i_cmd_tid,
    output logic             o_hdr_en,
    output logic             o_cp,
    output logic             o_toc,
    output logic [2:0]       o_mode,
    input  logic             i_xfer_done,
    input  logic             i_hdr_done,
    input  logic             i_abort,
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic [TID_W-1:0] o_resp_tid,
    output logic             o_resp_err,
    output logic             o_busy,
    output logic             o_timeout,
    output logic             o_chain_trunc
);
    localparam int         PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         CNT_W    = PTR_W + 1;
    localparam logic [2:0] MODE_DDR = 3'd6;

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_DRAIN, S_FLUSH} state_t;
    state_t state, state_nxt;

    // Command FIFO storage and bookkeeping
    logic             cmd_cp_mem   [DEPTH];
    logic             cmd_toc_mem  [DEPTH];
    logic [2:0]       cmd_mode_mem [DEPTH];
    logic [TID_W-1:0] cmd_tid_mem  [DEPTH];
    logic [PTR_W-1:0] cmd_wr_ptr, cmd_rd_ptr;
    logic [CNT_W-1:0] cmd_count, term_cnt;

    // Response FIFO storage and bookkeeping
    logic [TID_W-1:0] rsp_tid_mem [DEPTH];
    logic             rsp_err_mem [DEPTH];
    logic [PTR_W-1:0] rsp_wr_ptr, rsp_rd_ptr;
    logic [CNT_W-1:0] rsp_count;

    // Command currently owned by the engine
    logic             cur_cp, cur_toc;
    logic [2:0]       cur_mode;
    logic [TID_W-1:0] cur_tid;

    logic [TO_W-1:0]  wd_cnt;

    logic             head_cp, head_toc, head_term, cur_term, in_term;
    logic [2:0]       head_mode;
    logic [TID_W-1:0] head_tid;
    logic             inflight, cmd_push, force_toc, push_term, wd_expired, rsp_pop;
    logic [CNT_W:0]   occupancy;

    logic             cmd_pop, cur_load, rsp_push, rsp_push_err, hdr_en_nxt, timeout_fire;
    logic [TID_W-1:0] rsp_push_tid;
    logic             cfg_cp_nxt, cfg_toc_nxt;
    logic [2:0]       cfg_mode_nxt;

    assign head_cp   = cmd_cp_mem[cmd_rd_ptr];
    assign head_toc  = cmd_toc_mem[cmd_rd_ptr];
    assign head_mode = cmd_mode_mem[cmd_rd_ptr];
    assign head_tid  = cmd_tid_mem[cmd_rd_ptr];
    assign head_term = head_toc || (head_mode != MODE_DDR);
    assign cur_term  = cur_toc || (cur_mode != MODE_DDR);
    assign in_term   = i_cmd_toc || (i_cmd_mode != MODE_DDR);

    // A launched-but-unanswered command still owes a response slot
    assign inflight    = (state == S_LAUNCH) || (state == S_RUN);
    assign occupancy   = (CNT_W+1)'(cmd_count) + (CNT_W+1)'(rsp_count) + (CNT_W+1)'(inflight);
    assign o_cmd_ready = occupancy < (CNT_W+1)'(DEPTH);
    assign cmd_push    = i_cmd_valid && o_cmd_ready;

    // Filling the FIFO with an open chain would deadlock, so close it here
    assign force_toc = cmd_push && !in_term && (term_cnt == '0) && (cmd_count == CNT_W'(DEPTH - 1));
    assign push_term = in_term || force_toc;

    assign wd_expired = (wd_cnt == '1) && !i_xfer_done && !i_hdr_done &&
                        ((state == S_RUN) || (state == S_DRAIN));

    assign rsp_pop    = o_resp_valid && i_resp_ready;
    assign o_resp_tid = o_resp_valid ? rsp_tid_mem[rsp_rd_ptr] : '0;
    assign o_resp_err = o_resp_valid && rsp_err_mem[rsp_rd_ptr];

    // Next-state, FIFO control and engine configuration selection
    always_comb begin
        state_nxt    = state;
        cmd_pop      = 1'b0;
        cur_load     = 1'b0;
        rsp_push     = 1'b0;
        rsp_push_tid = cur_tid;
        rsp_push_err = 1'b0;
        hdr_en_nxt   = o_hdr_en;
        timeout_fire = 1'b0;
        cfg_cp_nxt   = o_cp;
        cfg_toc_nxt  = o_toc;
        cfg_mode_nxt = o_mode;
        unique case (state)
            S_IDLE: begin
                if (term_cnt != '0) begin
                    cmd_pop      = 1'b1;
                    cur_load     = 1'b1;
                    cfg_cp_nxt   = head_cp;
                    cfg_toc_nxt  = head_toc;
                    cfg_mode_nxt = head_mode;
                    state_nxt    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (i_abort) begin
                    rsp_push     = 1'b1;
                    rsp_push_err = 1'b1;
                    state_nxt    = S_FLUSH;
                end else begin
                    hdr_en_nxt   = 1'b1;
                    cfg_cp_nxt   = cur_cp;
                    cfg_toc_nxt  = cur_toc;
                    cfg_mode_nxt = cur_mode;
                    state_nxt    = S_RUN;
                end
            end
            S_RUN: begin
                if (i_xfer_done) begin
                    rsp_push = 1'b1;
                    if (i_abort) begin
                        hdr_en_nxt = 1'b0;
                        state_nxt  = S_FLUSH;
                    end else if (!cur_term) begin
                        cmd_pop      = 1'b1;
                        cur_load     = 1'b1;
                        cfg_cp_nxt   = head_cp;
                        cfg_toc_nxt  = head_toc;
                        cfg_mode_nxt = head_mode;
                    end else begin
                        state_nxt = S_DRAIN;
                    end
                end else if (i_abort || wd_expired) begin
                    hdr_en_nxt   = 1'b0;
                    rsp_push     = 1'b1;
                    rsp_push_err = 1'b1;
                    timeout_fire = wd_expired;
                    state_nxt    = S_FLUSH;
                end else if (!cur_term) begin
                    // Prefetch: the engine sees the next command's config early
                    cfg_cp_nxt   = head_cp;
                    cfg_toc_nxt  = head_toc;
                    cfg_mode_nxt = head_mode;
                end else begin
                    cfg_cp_nxt   = cur_cp;
                    cfg_toc_nxt  = cur_toc;
                    cfg_mode_nxt = cur_mode;
                end
            end
            S_DRAIN: begin
                if (i_abort || wd_expired) begin
                    hdr_en_nxt   = 1'b0;
                    timeout_fire = wd_expired;
                    state_nxt    = S_FLUSH;
                end else if (i_hdr_done) begin
                    hdr_en_nxt = 1'b0;
                    state_nxt  = S_IDLE;
                end
            end
            S_FLUSH: begin
                // A terminator in cur means the chain is already fully answered
                if (cur_term) begin
                    state_nxt = S_IDLE;
                end else begin
                    cmd_pop      = 1'b1;
                    rsp_push     = 1'b1;
                    rsp_push_tid = head_tid;
                    rsp_push_err = 1'b1;
                    if (head_term) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FIFO data arrays are plain storage; validity lives in the counters
    always_ff @(posedge i_sys_clk) begin
        if (cmd_push) begin
            cmd_cp_mem[cmd_wr_ptr]   <= i_cmd_cp;
            cmd_toc_mem[cmd_wr_ptr]  <= i_cmd_toc || force_toc;
            cmd_mode_mem[cmd_wr_ptr] <= i_cmd_mode;
            cmd_tid_mem[cmd_wr_ptr]  <= i_cmd_tid;
        end
        if (rsp_push) begin
            rsp_tid_mem[rsp_wr_ptr] <= rsp_push_tid;
            rsp_err_mem[rsp_wr_ptr] <= rsp_push_err;
        end
    end

    // Command FIFO pointers, occupancy and terminator count
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
            term_cnt   <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + PTR_W'(1);
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + PTR_W'(1);
            unique case ({cmd_push, cmd_pop})
                2'b10:   cmd_count <= cmd_count + CNT_W'(1);
                2'b01:   cmd_count <= cmd_count - CNT_W'(1);
                default: cmd_count <= cmd_count;
            endcase
            unique case ({cmd_push && push_term, cmd_pop && head_term})
                2'b10:   term_cnt <= term_cnt + CNT_W'(1);
                2'b01:   term_cnt <= term_cnt - CNT_W'(1);
                default: term_cnt <= term_cnt;
            endcase
        end
    end

    // Response FIFO pointers, occupancy and registered valid
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            rsp_wr_ptr   <= '0;
            rsp_rd_ptr   <= '0;
            rsp_count    <= '0;
            o_resp_valid <= 1'b0;
        end else begin
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + PTR_W'(1);
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + PTR_W'(1);
            unique case ({rsp_push, rsp_pop})
                2'b10:   rsp_count <= rsp_count + CNT_W'(1);
                2'b01:   rsp_count <= rsp_count - CNT_W'(1);
                default: rsp_count <= rsp_count;
            endcase
            o_resp_valid <= rsp_push || (rsp_count > CNT_W'(rsp_pop));
        end
    end

    // Current command and registered engine-facing outputs
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            cur_cp        <= 1'b0;
            cur_toc       <= 1'b0;
            cur_mode      <= MODE_DDR;
            cur_tid       <= '0;
            o_hdr_en      <= 1'b0;
            o_cp          <= 1'b0;
            o_toc         <= 1'b0;
            o_mode        <= MODE_DDR;
            o_busy        <= 1'b0;
            o_timeout     <= 1'b0;
            o_chain_trunc <= 1'b0;
        end else begin
            if (cur_load) begin
                cur_cp   <= head_cp;
                cur_toc  <= head_toc;
                cur_mode <= head_mode;
                cur_tid  <= head_tid;
            end
            o_hdr_en      <= hdr_en_nxt;
            o_cp          <= cfg_cp_nxt;
            o_toc         <= cfg_toc_nxt;
            o_mode        <= cfg_mode_nxt;
            o_busy        <= (state_nxt != S_IDLE);
            o_timeout     <= timeout_fire;
            o_chain_trunc <= force_toc;
        end
    end

    // Watchdog: counts cycles without engine progress while the engine is enabled
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            wd_cnt <= '0;
        end else if ((state == S_LAUNCH) || i_xfer_done || i_hdr_done) begin
            wd_cnt <= '0;
        end else if ((state == S_RUN) || (state == S_DRAIN)) begin
            wd_cnt <= wd_cnt + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_hdr_cmd_sequencer.sv
// tb/tb_hdr_cmd_sequencer.sv - directed self-checking bench for hdr_cmd_sequencer
module tb_hdr_cmd_sequencer;
    logic       i_sys_clk;
    logic       i_sys_rst_n;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic       i_cmd_cp;
    logic       i_cmd_toc;
    logic [2:0] i_cmd_mode;
    logic [3:0] i_cmd_tid;
    logic       o_hdr_en;
    logic       o_cp;
    logic       o_toc;
    logic [2:0] o_mode;
    logic       i_xfer_done;
    logic       i_hdr_done;
    logic       i_abort;
    logic       o_resp_valid;
    logic       i_resp_ready;
    logic [3:0] o_resp_tid;
    logic       o_resp_err;
    logic       o_busy;
    logic       o_timeout;
    logic       o_chain_trunc;

    int n_checks = 0;
    int n_pass   = 0;

    hdr_cmd_sequencer #(.DEPTH(4), .TID_W(4), .TO_W(10)) dut (
        .i_sys_clk     (i_sys_clk),
        .i_sys_rst_n   (i_sys_rst_n),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_cp      (i_cmd_cp),
        .i_cmd_toc     (i_cmd_toc),
        .i_cmd_mode    (i_cmd_mode),
        .i_cmd_tid     (i_cmd_tid),
        .o_hdr_en      (o_hdr_en),
        .o_cp          (o_cp),
        .o_toc         (o_toc),
        .o_mode        (o_mode),
        .i_xfer_done   (i_xfer_done),
        .i_hdr_done    (i_hdr_done),
        .i_abort       (i_abort),
        .o_resp_valid  (o_resp_valid),
        .i_resp_ready  (i_resp_ready),
        .o_resp_tid    (o_resp_tid),
        .o_resp_err    (o_resp_err),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout),
        .o_chain_trunc (o_chain_trunc)
    );

    initial begin
        i_sys_clk = 1'b0;
        forever #5 i_sys_clk = ~i_sys_clk;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation time budget exceeded");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input int cp, input int toc, input int mode, input int tid);
        int n;
        n = 0;
        i_cmd_cp    = cp[0];
        i_cmd_toc   = toc[0];
        i_cmd_mode  = 3'(mode);
        i_cmd_tid   = 4'(tid);
        i_cmd_valid = 1'b1;
        while (!o_cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check_eq("push_ready", int'(o_cmd_ready), 1);
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic xfer_done();
        i_xfer_done = 1'b1;
        tick();
        i_xfer_done = 1'b0;
    endtask

    task automatic hdr_done();
        i_hdr_done = 1'b1;
        tick();
        i_hdr_done = 1'b0;
    endtask

    task automatic wait_en();
        int n;
        n = 0;
        while (!o_hdr_en && n < 50) begin
            tick();
            n++;
        end
        check_eq("en_rise", int'(o_hdr_en), 1);
    endtask

    task automatic pop_resp(input int tid, input int err);
        int n;
        n = 0;
        while (!o_resp_valid && n < 50) begin
            tick();
            n++;
        end
        check_eq("resp_valid", int'(o_resp_valid), 1);
        check_eq("resp_tid", int'(o_resp_tid), tid);
        check_eq("resp_err", int'(o_resp_err), err);
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
    endtask

    initial begin
        int n;
        i_sys_rst_n  = 1'b0;
        i_cmd_valid  = 1'b0;
        i_cmd_cp     = 1'b0;
        i_cmd_toc    = 1'b0;
        i_cmd_mode   = 3'd6;
        i_cmd_tid    = 4'd0;
        i_xfer_done  = 1'b0;
        i_hdr_done   = 1'b0;
        i_abort      = 1'b0;
        i_resp_ready = 1'b0;
        idle(3);

        // reset values
        check_eq("rst_hdr_en", int'(o_hdr_en), 0);
        check_eq("rst_mode", int'(o_mode), 6);
        check_eq("rst_toc", int'(o_toc), 0);
        check_eq("rst_cmd_ready", int'(o_cmd_ready), 1);
        check_eq("rst_resp_valid", int'(o_resp_valid), 0);
        check_eq("rst_busy", int'(o_busy), 0);
        i_sys_rst_n = 1'b1;
        idle(2);

        // single DDR command
        push(0, 1, 6, 3);
        check_eq("single_en_at_push", int'(o_hdr_en), 0);
        tick();
        check_eq("single_launch_busy", int'(o_busy), 1);
        check_eq("single_launch_en", int'(o_hdr_en), 0);
        tick();
        check_eq("single_en_t2", int'(o_hdr_en), 1);
        check_eq("single_toc", int'(o_toc), 1);
        check_eq("single_mode", int'(o_mode), 6);
        idle(18);
        xfer_done();
        check_eq("single_resp_valid", int'(o_resp_valid), 1);
        check_eq("single_drain_en", int'(o_hdr_en), 1);
        idle(2);
        hdr_done();
        check_eq("single_exit_en", int'(o_hdr_en), 0);
        check_eq("single_exit_busy", int'(o_busy), 0);
        pop_resp(3, 0);
        check_eq("single_resp_empty", int'(o_resp_valid), 0);

        // chain of three with prefetch
        push(1, 0, 6, 1);
        push(0, 0, 6, 2);
        push(0, 1, 6, 4);
        tick();
        check_eq("chain_launch_cp", int'(o_cp), 1);
        tick();
        check_eq("chain_run_en", int'(o_hdr_en), 1);
        check_eq("chain_run_cp_first", int'(o_cp), 1);
        tick();
        check_eq("chain_prefetch_cp", int'(o_cp), 0);
        idle(2);
        xfer_done();
        tick();
        check_eq("chain_prefetch_toc", int'(o_toc), 1);
        idle(2);
        xfer_done();
        idle(2);
        xfer_done();
        idle(2);
        check_eq("chain_drain_en", int'(o_hdr_en), 1);
        hdr_done();
        check_eq("chain_exit_en", int'(o_hdr_en), 0);
        pop_resp(1, 0);
        pop_resp(2, 0);
        pop_resp(4, 0);

        // backpressure on the response side
        push(0, 1, 6, 5);
        wait_en();
        idle(3);
        xfer_done();
        idle(1);
        hdr_done();
        push(0, 1, 6, 6);
        push(0, 1, 6, 7);
        push(0, 1, 6, 8);
        check_eq("bp_ready_full", int'(o_cmd_ready), 0);
        wait_en();
        idle(2);
        xfer_done();
        idle(1);
        hdr_done();
        idle(2);
        check_eq("bp_ready_still_full", int'(o_cmd_ready), 0);
        pop_resp(5, 0);
        check_eq("bp_ready_after_pop", int'(o_cmd_ready), 1);
        wait_en();
        idle(2);
        xfer_done();
        idle(1);
        hdr_done();
        wait_en();
        idle(2);
        xfer_done();
        idle(1);
        hdr_done();
        pop_resp(6, 0);
        pop_resp(7, 0);
        pop_resp(8, 0);

        // forced terminator
        push(0, 0, 6, 9);
        push(0, 0, 6, 10);
        push(0, 0, 6, 11);
        check_eq("trunc_not_yet", int'(o_chain_trunc), 0);
        push(0, 0, 6, 12);
        check_eq("trunc_pulse", int'(o_chain_trunc), 1);
        tick();
        check_eq("trunc_one_cycle", int'(o_chain_trunc), 0);
        wait_en();
        idle(2);
        xfer_done();
        idle(2);
        xfer_done();
        idle(2);
        xfer_done();
        check_eq("trunc_forced_toc", int'(o_toc), 1);
        idle(2);
        xfer_done();
        idle(2);
        check_eq("trunc_drain_en", int'(o_hdr_en), 1);
        hdr_done();
        pop_resp(9, 0);
        pop_resp(10, 0);
        pop_resp(11, 0);
        pop_resp(12, 0);

        // watchdog timeout with a later chain queued
        push(0, 0, 6, 1);
        push(0, 0, 6, 2);
        push(0, 1, 6, 3);
        push(1, 1, 6, 13);
        wait_en();
        n = 0;
        while (!o_timeout && n < 1100) begin
            tick();
            n++;
        end
        check_eq("to_fired", int'(o_timeout), 1);
        check_eq("to_window", int'((n >= 1023) && (n <= 1025)), 1);
        check_eq("to_en_low", int'(o_hdr_en), 0);
        tick();
        check_eq("to_pulse_one", int'(o_timeout), 0);
        pop_resp(1, 1);
        pop_resp(2, 1);
        pop_resp(3, 1);
        wait_en();
        idle(2);
        xfer_done();
        idle(1);
        hdr_done();
        pop_resp(13, 0);

        // abort during RUN flushes the chain
        push(0, 0, 6, 5);
        push(0, 1, 6, 6);
        wait_en();
        idle(2);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_eq("abort_en_low", int'(o_hdr_en), 0);
        check_eq("abort_no_timeout", int'(o_timeout), 0);
        pop_resp(5, 1);
        pop_resp(6, 1);
        check_eq("abort_busy_low", int'(o_busy), 0);

        // reset mid-RUN
        push(1, 1, 6, 7);
        wait_en();
        check_eq("rst_mid_cp_before", int'(o_cp), 1);
        #2;
        i_sys_rst_n = 1'b0;
        #1;
        check_eq("rst_mid_en", int'(o_hdr_en), 0);
        check_eq("rst_mid_cp", int'(o_cp), 0);
        check_eq("rst_mid_toc", int'(o_toc), 0);
        check_eq("rst_mid_mode", int'(o_mode), 6);
        check_eq("rst_mid_busy", int'(o_busy), 0);
        check_eq("rst_mid_ready", int'(o_cmd_ready), 1);
        check_eq("rst_mid_resp_valid", int'(o_resp_valid), 0);
        tick();
        i_sys_rst_n = 1'b1;
        idle(4);
        check_eq("post_rst_no_resp", int'(o_resp_valid), 0);
        check_eq("post_rst_idle", int'(o_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hdr_cmd_sequencer.md
# hdr_cmd_sequencer

HDR command sequencer that sits between the register-file command queue and `hdr_engine`. It buffers HDR command descriptors (CP, TOC, MODE, TID) and launches chains of commands into the engine. It presents each next descriptor on the engine's configuration inputs before the current transfer completes, and returns one response per command. A watchdog and an abort input recover a hung transfer by dropping the engine enable and flushing the rest of the chain with error responses.

## Interface
- `DEPTH`, default 4: command FIFO entries, power of two, ≥2.
- `TID_W`, default 4: transaction ID width.
- `TO_W`, default 10: watchdog counter width; timeout fires after 2^TO_W−1 cycles without progress.
- `i_sys_clk` in 1: system clock. Single clock domain.
- `i_sys_rst_n` in 1: asynchronous, active-low reset.
- `i_cmd_valid` in 1: command push request.
- `o_cmd_ready` out 1: push accepted when valid & ready at a rising edge.
- `i_cmd_cp` in 1: 1 = CCC, 0 = normal DDR transfer.
- `i_cmd_toc` in 1: 1 = exit after this command, 0 = restart.
- `i_cmd_mode` in 3: HDR mode; 3'd6 = HDR-DDR.
- `i_cmd_tid` in TID_W: transaction ID.
- `o_hdr_en` out 1: drives `hdr_engine` enable.
- `o_cp`, `o_toc` out 1 each; `o_mode` out 3: drive the engine's CP/TOC/MODE inputs.
- `i_xfer_done` in 1: per-command completion pulse (OR of ccc_done and ddr_mode_done).
- `i_hdr_done` in 1: engine exit done.
- `i_abort` in 1: software abort, level-sampled.
- `o_resp_valid` out 1; `i_resp_ready` in 1: response handshake.
- `o_resp_tid` out TID_W: response transaction ID.
- `o_resp_err` out 1: 1 = timed out, aborted, or flushed.
- `o_busy` out 1: high in any state other than IDLE.
- `o_timeout` out 1: one-cycle pulse when the watchdog fires.
- `o_chain_trunc` out 1: one-cycle pulse when TOC is forced on a push.

## Operation
- **Terminator:** a command with toc=1 or mode≠6.
- **Command FIFO:**
  - DEPTH entries, registered, pointer wrap modulo DEPTH.
  - Keeps `term_cnt`, the number of terminators stored.
- **Response FIFO:** DEPTH entries of {tid, err}.
- **Push admission:** `o_cmd_ready` = (cmd_count + resp_count + inflight < DEPTH), where inflight = 1 while a current command is held. This guarantees the response FIFO never overflows and the engine is never stalled.
- **Forced terminator:** a push that fills the last free command slot while term_cnt=0 is stored with toc forced to 1, and `o_chain_trunc` pulses.
- **FSM states:** IDLE, LAUNCH, RUN, DRAIN, FLUSH.
  - **IDLE:** if term_cnt>0, pop the head into `cur` → LAUNCH.
  - **LAUNCH (1 cycle):** o_cp/o_toc/o_mode = cur; o_hdr_en=0. Registers o_hdr_en=1 → RUN.
  - **RUN, first cycle:** config outputs still equal cur.
  - **RUN, afterwards:** if cur is not a terminator, config outputs = FIFO head (prefetch, not popped); if cur is a terminator, outputs hold cur.
  - **RUN on i_xfer_done:**
    - Push the response {cur.tid, 0}.
    - If cur is not a terminator: cur ← head, pop, stay in RUN.
    - If cur is a terminator: → DRAIN.
  - **DRAIN:** o_hdr_en stays 1 until i_hdr_done, then o_hdr_en=0 → IDLE.
  - **Timeout or abort:** the watchdog expiring in RUN/DRAIN, or i_abort=1 in LAUNCH/RUN/DRAIN, does the following:
    - o_hdr_en←0.
    - Push {cur.tid, 1} unless cur's response was already pushed.
    - Go to FLUSH.
  - **FLUSH:** pop one entry per cycle, pushing {tid, 1} for each, up to and including the next terminator, then → IDLE. Entries of later chains are untouched.
- **Watchdog:** resets to 0 on entering RUN and on every i_xfer_done or i_hdr_done; increments otherwise in RUN/DRAIN; fires at all-ones. o_timeout pulses only on watchdog expiry, not on abort.
- **Simultaneous events:**
  - Push and pop in the same cycle: both occur, count unchanged.
  - Response push and pop in the same cycle: both occur.
  - i_xfer_done together with watchdog expiry: done wins and the watchdog clears.
  - i_abort together with i_xfer_done: the ok response is pushed first, then FLUSH.
- **Reset mid-operation:** all state is cleared and FIFO contents are discarded; no responses are generated.

## Timing
- **Reset values:**
  - o_hdr_en=0, o_cp=0, o_toc=0, o_mode=3'd6.
  - o_resp_valid=0, o_resp_tid=0, o_resp_err=0.
  - o_busy=0, o_timeout=0, o_chain_trunc=0.
  - o_cmd_ready=1.
- All outputs are registered except o_cmd_ready and the response FIFO head fields.
- **Latency:**
  - Push of a terminator at edge t into an empty FIFO: LAUNCH at t+1, o_hdr_en=1 from t+2.
  - i_xfer_done at edge t: o_resp_valid=1 at t+1 if the response FIFO was empty.
- **Config update:** the next command's config appears on o_cp/o_toc/o_mode by the cycle after the previous done, and is stable at least 1 cycle before that command's i_xfer_done.
- **Response hold:** o_resp_valid/tid/err stay stable until accepted.

## Test plan
- **Single DDR command:** push {cp0, toc1, mode6, tid3}; done after 20 cycles, then i_hdr_done → en high 2 cycles after push; one response {3,0}; o_busy low after exit.
- **Chain:** push {cp1,toc0,tid1}, {cp0,toc0,tid2}, {cp0,toc1,tid4} → o_cp shows 0 before the first done; responses 1,2,4 in order, all err=0; single DRAIN.
- **Backpressure:** hold i_resp_ready=0 with DEPTH=4 → o_cmd_ready falls once 4 commands are queued or completed; no response is lost; ready returns after 1 pop.
- **Forced terminator:** push 4 toc0 commands → 4th stored with toc=1; o_chain_trunc pulses once; chain launches.
- **Timeout:** chain of 3, no i_xfer_done for 1023 cycles (TO_W=10) → o_timeout pulse, en=0, responses {tid1,1}, {tid2,1}, {tid3,1}; a later queued chain is untouched.
- **Abort + reset:** i_abort during RUN → FLUSH; then assert reset mid-RUN → all outputs at reset values within the same cycle.
